// File: rtl/fp16_pkg.sv
// Shared FP16 constants and the dot-feeder FSM encoding.
package fp16_pkg;

  localparam logic [15:0] FP16_POS_ZERO   = 16'h0000;
  localparam logic [15:0] FP16_ONE        = 16'h3C00;
  localparam int          MUL_LAT_DEFAULT = 5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    HOLD   = 3'd4
  } fsm_state_t;

endpackage

// File: rtl/fp_dot_cnt.sv
// Loadable down-counter with zero flag; saturates at zero.
module fp_dot_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (rst)                     cnt <= '0;
    else if (load)               cnt <= load_val;
    else if (dec && cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/regN.sv
// Generic enabled register with synchronous clear.
module regN #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/fp16_dot_feeder.sv
// Streams FP16 operand pairs into a MAC, flushes its multiplier pipe and
// returns the settled accumulator as one dot-product result.
module fp16_dot_feeder
  import fp16_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEFAULT,
  parameter int LEN_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  output logic             mac_clr,
  output logic [15:0]      mac_a,
  output logic [15:0]      mac_b,
  input  logic [15:0]      mac_acc,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_data
);

  localparam int                 DRAIN_W    = $clog2(MUL_LAT + 2);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(MUL_LAT + 1);

  fsm_state_t         state;
  logic               post_rst;
  logic [LEN_W-1:0]   pair_cnt;
  logic               pair_zero;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               drain_zero;
  logic               beat, last_beat, job_go, zero_job, drain_done, cap;
  logic [15:0]        cap_d;

  assign beat       = in_valid & in_ready;
  assign last_beat  = beat && (pair_cnt == LEN_W'(1));
  assign job_go     = (state == IDLE) && start;
  assign zero_job   = job_go && (len == '0);
  assign drain_done = (state == DRAIN) && drain_zero;
  assign cap        = zero_job | drain_done;
  // An empty job reports +0 without ever touching the MAC.
  assign cap_d      = zero_job ? FP16_POS_ZERO : mac_acc;

  fp_dot_cnt #(.W(LEN_W)) u_pair_cnt (
    .clk(clk), .rst(rst), .load(job_go), .load_val(len),
    .dec(beat), .cnt(pair_cnt), .zero(pair_zero)
  );

  fp_dot_cnt #(.W(DRAIN_W)) u_drain_cnt (
    .clk(clk), .rst(rst), .load(last_beat), .load_val(DRAIN_LOAD),
    .dec(state == DRAIN), .cnt(drain_cnt), .zero(drain_zero)
  );

  regN #(.WIDTH(16)) u_res_reg (
    .clk(clk), .rst(rst), .en(cap), .d(cap_d), .q(res_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
      mac_a     <= FP16_POS_ZERO;
      mac_b     <= FP16_POS_ZERO;
      res_valid <= 1'b0;
      mac_clr   <= 1'b1;
      post_rst  <= 1'b1;
    end else begin
      // Keep the MAC in clear for one extra cycle after reset release.
      post_rst <= 1'b0;
      mac_clr  <= post_rst;
      mac_a    <= beat ? in_a : FP16_POS_ZERO;
      mac_b    <= beat ? in_b : FP16_POS_ZERO;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (len == '0) begin
              state     <= HOLD;
              res_valid <= 1'b1;
            end else begin
              state   <= CLEAR;
              mac_clr <= 1'b1;
            end
          end
        end
        CLEAR: begin
          state    <= STREAM;
          in_ready <= 1'b1;
        end
        STREAM: begin
          if (last_beat) begin
            state    <= DRAIN;
            in_ready <= 1'b0;
          end
        end
        DRAIN: begin
          if (drain_zero) begin
            state     <= HOLD;
            res_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          in_ready  <= 1'b0;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_dot_feeder.sv
// Bench for fp16_dot_feeder paired with a behavioural FP16 MAC; results are
// checked against a dot product computed from the operand lists.
`timescale 1ns/1ps
module tb_fp16_dot_feeder;
  import fp16_pkg::*;

  localparam int MUL_LAT = 5;
  localparam int LEN_W   = 8;

  logic             clk = 1'b0;
  logic             rst, start, in_valid, res_ready;
  logic [LEN_W-1:0] len;
  logic [15:0]      in_a, in_b, mac_a, mac_b, mac_acc, res_data;
  logic             busy, in_ready, mac_clr, res_valid;

  int checks = 0;
  int errors = 0;

  logic [15:0] pool [0:7];
  logic [15:0] pa [0:255];
  logic [15:0] pb [0:255];

  always #5 clk = ~clk;

  fp16_dot_feeder #(.MUL_LAT(MUL_LAT), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mac_clr(mac_clr), .mac_a(mac_a), .mac_b(mac_b), .mac_acc(mac_acc),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  function automatic real fp16_to_real(input logic [15:0] h);
    real m;
    int  e;
    if (h[14:0] == 15'd0) return 0.0;
    e = int'(h[14:10]) - 15;
    m = 1.0 + real'(h[9:0]) / 1024.0;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] real_to_fp16(input real x);
    real  m;
    int   e;
    int   f;
    logic s;
    if (x == 0.0) return 16'h0000;
    s = (x < 0.0);
    m = s ? -x : x;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    f = $rtoi((m - 1.0) * 1024.0);
    return {s, 5'(e + 15), 10'(f)};
  endfunction

  // Behavioural MAC: MUL_LAT-deep product pipe feeding an accumulator.
  real pipe [MUL_LAT];
  real acc = 0.0;
  always @(posedge clk) begin
    if (mac_clr) begin
      for (int i = 0; i < MUL_LAT; i++) pipe[i] <= 0.0;
      acc <= 0.0;
    end else begin
      acc     <= acc + pipe[MUL_LAT-1];
      pipe[0] <= fp16_to_real(mac_a) * fp16_to_real(mac_b);
      for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign mac_acc = real_to_fp16(acc);

  function automatic logic [15:0] dot_ref(input int n);
    real s;
    s = 0.0;
    for (int i = 0; i < n; i++) s = s + fp16_to_real(pa[i]) * fp16_to_real(pb[i]);
    return real_to_fp16(s);
  endfunction

  // Runs one job. Start is driven in cycle 0; lat is the cycle in which
  // res_valid is first seen (or rst_at, where the job is abandoned).
  task automatic do_job(input int n, input int gap, input int rst_at,
                        output logic [15:0] res, output int lat,
                        output int clr_cnt, output int rdy_cnt);
    int          idx, wcnt;
    logic        acc_now;
    logic [15:0] ea, eb;
    res = 16'h0; lat = -1; clr_cnt = 0; rdy_cnt = 0;
    idx = 0; wcnt = 0; ea = 16'h0; eb = 16'h0;
    start = 1'b1; len = LEN_W'(n); in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc < 3000; cyc++) begin
      checks++;
      if (mac_a !== ea || mac_b !== eb) begin
        errors++;
        $display("FAIL mac_operands cyc=%0d got %h/%h exp %h/%h", cyc, mac_a, mac_b, ea, eb);
      end
      if (mac_clr)  clr_cnt++;
      if (in_ready) rdy_cnt++;
      if (res_valid) begin lat = cyc; res = res_data; break; end
      if (cyc == rst_at) begin lat = cyc; break; end
      if (idx < n && wcnt == 0) begin
        in_valid = 1'b1; in_a = pa[idx]; in_b = pb[idx];
      end else begin
        in_valid = 1'b0; in_a = 16'($urandom); in_b = 16'($urandom);
        if (wcnt > 0) wcnt--;
      end
      acc_now = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc_now) begin ea = in_a; eb = in_b; idx++; wcnt = gap; end
      else begin ea = 16'h0; eb = 16'h0; end
    end
    in_valid = 1'b0;
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL job_timeout n=%0d got no res_valid exp within 3000 cycles", n);
    end
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (!busy) break;
    end
    if (k == 50) begin
      checks++; errors++;
      $display("FAIL wait_idle busy=%b exp 0", busy);
    end
  endtask

  task automatic check_job(input string name, input int n, input int gap,
                           input logic [15:0] exp_res);
    logic [15:0] res;
    int          lat, clr, rdy, exp_lat;
    exp_lat = (n == 0) ? 1 : n + MUL_LAT + 4 + gap * (n - 1);
    do_job(n, gap, 0, res, lat, clr, rdy);
    checks++;
    if (res !== exp_res) begin
      errors++; $display("FAIL %s_result got %h exp %h", name, res, exp_res);
    end
    checks++;
    if (lat != exp_lat) begin
      errors++; $display("FAIL %s_latency got %0d exp %0d", name, lat, exp_lat);
    end
    checks++;
    if (clr != ((n == 0) ? 0 : 1) || rdy != ((n == 0) ? 0 : n + gap * (n - 1))) begin
      errors++; $display("FAIL %s_handshake got clr=%0d rdy=%0d exp clr=%0d rdy=%0d",
                         name, clr, rdy, (n == 0) ? 0 : 1, (n == 0) ? 0 : n + gap * (n - 1));
    end
    wait_idle();
  endtask

  task automatic check_reset_vals(input string name);
    checks++;
    if ({busy, in_ready, res_valid, mac_clr, mac_a, mac_b, res_data} !== {4'b0001, 48'h0}) begin
      errors++;
      $display("FAIL %s got busy=%b rdy=%b rv=%b clr=%b a=%h b=%h rd=%h exp 0/0/0/1/0000/0000/0000",
               name, busy, in_ready, res_valid, mac_clr, mac_a, mac_b, res_data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; res_ready = 1'b1;
    len = '0; in_a = 16'h0; in_b = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset_state");
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (mac_clr !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_release got clr=%b busy=%b exp 1/0", mac_clr, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (mac_clr !== 1'b0) begin
      errors++; $display("FAIL reset_clr_drop got %b exp 0", mac_clr);
    end
  endtask

  task automatic test_basic();
    pa[0] = 16'h3C00; pb[0] = 16'h4000;
    pa[1] = 16'h4000; pb[1] = 16'h4200;
    check_job("basic", 2, 0, 16'h4800);
  endtask

  task automatic test_bubbles();
    pa[0] = 16'h3C00; pb[0] = 16'h4000;
    pa[1] = 16'h4000; pb[1] = 16'h4200;
    check_job("bubbles", 2, 3, 16'h4800);
  endtask

  task automatic test_len_zero();
    check_job("len_zero", 0, 0, 16'h0000);
  endtask

  task automatic test_two_jobs();
    pa[0] = 16'h3800; pb[0] = 16'h4000;
    check_job("job_a", 1, 0, 16'h3C00);
    pa[0] = 16'h4200; pb[0] = 16'h3C00;
    check_job("job_b", 1, 0, 16'h4200);
  endtask

  task automatic test_hold_stall();
    logic [15:0] res;
    int          lat, clr, rdy;
    for (int i = 0; i < 3; i++) begin
      pa[i] = pool[$urandom_range(0, 7)]; pb[i] = pool[$urandom_range(0, 7)];
    end
    res_ready = 1'b0;
    do_job(3, 0, 0, res, lat, clr, rdy);
    checks++;
    if (res !== dot_ref(3)) begin
      errors++; $display("FAIL stall_result got %h exp %h", res, dot_ref(3));
    end
    for (int i = 0; i < 10; i++) begin
      start = 1'b1; len = LEN_W'($urandom_range(0, 9));
      @(posedge clk); #1;
      checks++;
      if ({res_valid, busy, in_ready, mac_clr, res_data} !== {4'b1100, dot_ref(3)}) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d got rv=%b busy=%b rdy=%b clr=%b rd=%h exp 1/1/0/0/%h",
                 i, res_valid, busy, in_ready, mac_clr, res_data, dot_ref(3));
      end
    end
    // Release with start still high: the HOLD exit must not launch a job.
    res_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL stall_release got rv=%b busy=%b exp 0/0", res_valid, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || mac_clr !== 1'b0) begin
      errors++; $display("FAIL exit_start_ignored got busy=%b clr=%b exp 0/0", busy, mac_clr);
    end
  endtask

  task automatic test_rst_drain();
    logic [15:0] res;
    int          lat, clr, rdy;
    for (int i = 0; i < 4; i++) begin
      pa[i] = pool[$urandom_range(0, 7)]; pb[i] = pool[$urandom_range(0, 7)];
    end
    do_job(4, 0, 8, res, lat, clr, rdy);
    checks++;
    if (lat != 8) begin
      errors++; $display("FAIL drain_early_result got lat=%0d exp 8", lat);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("rst_in_drain");
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (mac_clr !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_after got clr=%b rv=%b busy=%b exp 1/0/0", mac_clr, res_valid, busy);
    end
    @(posedge clk); #1;
    pa[0] = 16'h3C00; pb[0] = 16'h3C00;
    check_job("after_rst", 1, 0, 16'h3C00);
  endtask

  task automatic test_random();
    int n, gap;
    for (int j = 0; j < 6; j++) begin
      n   = $urandom_range(1, 16);
      gap = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) begin
        pa[i] = pool[$urandom_range(0, 7)]; pb[i] = pool[$urandom_range(0, 7)];
      end
      check_job("random", n, gap, dot_ref(n));
    end
    // Maximum length with +-1 products keeps every partial sum exact.
    for (int i = 0; i < 255; i++) begin
      pa[i] = ($urandom_range(0, 1) != 0) ? 16'h3C00 : 16'hBC00;
      pb[i] = FP16_ONE;
    end
    check_job("max_len", 255, 0, dot_ref(255));
  endtask

  initial begin
    pool[0] = 16'h3800; pool[1] = 16'h3C00; pool[2] = 16'h3E00; pool[3] = 16'h4000;
    pool[4] = 16'h4200; pool[5] = 16'hB800; pool[6] = 16'hBC00; pool[7] = 16'hC000;
    test_reset();
    test_basic();
    test_bubbles();
    test_len_zero();
    test_two_jobs();
    test_hold_stall();
    test_rst_drain();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish exp finish before 2ms");
    $fatal(1);
  end

endmodule
